// File: rtl/tensor_hmma_sequencer_if.sv
// Issue-side macro-op and tensor-core-side uop bundles for the HMMA sequencer.
// master drives macro-ops and consumes uops; slave is the sequencer.
interface tensor_hmma_sequencer_if #(
  parameter int NUM_THREADS = 32,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 44,
  parameter int NW_WIDTH    = 2,
  parameter int NR_BITS     = 6
);
  logic                   in_valid;
  logic                   in_ready;
  logic [UUID_WIDTH-1:0]  in_uuid;
  logic [NW_WIDTH-1:0]    in_wid;
  logic [NUM_THREADS-1:0] in_tmask;
  logic [XLEN-1:0]        in_pc;
  logic                   in_wb;
  logic [NR_BITS-1:0]     in_rd_base;
  logic [NR_BITS-1:0]     in_rs1_base;
  logic [NR_BITS-1:0]     in_rs2_base;
  logic [NR_BITS-1:0]     in_rs3_base;

  logic                   out_valid;
  logic                   out_ready;
  logic [UUID_WIDTH-1:0]  out_uuid;
  logic [NW_WIDTH-1:0]    out_wid;
  logic [NUM_THREADS-1:0] out_tmask;
  logic [XLEN-1:0]        out_pc;
  logic                   out_wb;
  logic [1:0]             out_op_type;
  logic                   out_substep;
  logic [NR_BITS-1:0]     out_rd;
  logic [NR_BITS-1:0]     out_rs1;
  logic [NR_BITS-1:0]     out_rs2;
  logic [NR_BITS-1:0]     out_rs3;
  logic                   out_last;

  modport master (
    output in_valid, in_uuid, in_wid, in_tmask, in_pc, in_wb,
    output in_rd_base, in_rs1_base, in_rs2_base, in_rs3_base,
    input  in_ready,
    input  out_valid, out_uuid, out_wid, out_tmask, out_pc, out_wb,
    input  out_op_type, out_substep,
    input  out_rd, out_rs1, out_rs2, out_rs3, out_last,
    output out_ready
  );

  modport slave (
    input  in_valid, in_uuid, in_wid, in_tmask, in_pc, in_wb,
    input  in_rd_base, in_rs1_base, in_rs2_base, in_rs3_base,
    output in_ready,
    output out_valid, out_uuid, out_wid, out_tmask, out_pc, out_wb,
    output out_op_type, out_substep,
    output out_rd, out_rs1, out_rs2, out_rs3, out_last,
    input  out_ready
  );
endinterface

// File: rtl/tensor_hmma_sequencer.sv
// Expands one HMMA macro-op into 8 tensor-core uops (4 steps x 2 substeps).
// Optional perf counters enabled by defining TENSOR_SEQ_PERF_EN.
module tensor_hmma_sequencer #(
  parameter int ISW         = 0,
  parameter int NUM_THREADS = 32,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 44,
  parameter int NW_WIDTH    = 2,
  parameter int NR_BITS     = 6
) (
  input  logic        clk,
  input  logic        reset,
  tensor_hmma_sequencer_if.slave bus,
  output logic        busy,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stalls
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state;
  logic [2:0]             cnt;
  logic [UUID_WIDTH-1:0]  uuid_q;
  logic [NW_WIDTH-1:0]    wid_q;
  logic [NUM_THREADS-1:0] tmask_q;
  logic [XLEN-1:0]        pc_q;
  logic                   wb_q;
  logic [NR_BITS-1:0]     rd_q;
  logic [NR_BITS-1:0]     rs1_q;
  logic [NR_BITS-1:0]     rs2_q;
  logic [NR_BITS-1:0]     rs3_q;

  logic last;
  logic in_fire;
  logic out_fire;

  assign busy     = (state == ISSUE);
  assign last     = busy && (cnt == 3'd7);
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = busy && bus.out_ready;

  // Accepting on the last-uop fire lets ops run back to back.
  assign bus.in_ready = !busy || (last && bus.out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      uuid_q  <= '0;
      wid_q   <= '0;
      tmask_q <= '0;
      pc_q    <= '0;
      wb_q    <= 1'b0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            state <= ISSUE;
            cnt   <= 3'd0;
          end
        end
        ISSUE: begin
          if (out_fire) begin
            if (cnt != 3'd7) begin
              cnt <= cnt + 3'd1;
            end else begin
              cnt <= 3'd0;
              if (!bus.in_valid) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (in_fire) begin
        uuid_q  <= bus.in_uuid;
        wid_q   <= bus.in_wid;
        tmask_q <= bus.in_tmask;
        pc_q    <= bus.in_pc;
        wb_q    <= bus.in_wb;
        rd_q    <= bus.in_rd_base;
        rs1_q   <= bus.in_rs1_base;
        rs2_q   <= bus.in_rs2_base;
        rs3_q   <= bus.in_rs3_base;
      end
    end
  end

  assign bus.out_valid   = busy;
  assign bus.out_last    = last;
  assign bus.out_uuid    = uuid_q;
  assign bus.out_wid     = wid_q;
  assign bus.out_tmask   = tmask_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_wb      = wb_q;
  assign bus.out_op_type = cnt[2:1];
  assign bus.out_substep = cnt[0];
  // A/B rows alternate per substep; C and D walk all 8 registers.
  assign bus.out_rs1 = rs1_q + NR_BITS'(cnt[0]);
  assign bus.out_rs2 = rs2_q + NR_BITS'(cnt[0]);
  assign bus.out_rs3 = rs3_q + NR_BITS'(cnt);
  assign bus.out_rd  = rd_q + NR_BITS'(cnt);

`ifdef TENSOR_SEQ_PERF_EN
  logic [31:0] ops_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ops_q    <= 32'd0;
      stalls_q <= 32'd0;
    end else begin
      if (out_fire && last) ops_q <= ops_q + 32'd1;
      if (busy && !bus.out_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_ops    = ops_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_ops    = 32'd0;
  assign perf_stalls = 32'd0;
`endif
endmodule

// File: tb/tb_tensor_hmma_sequencer.sv
// Scoreboard bench for tensor_hmma_sequencer: directed cases then random ops.
// Reference model expands each accepted op arithmetically into 8 uops.
module tb_tensor_hmma_sequencer;
  typedef struct packed {
    logic [43:0] uuid;
    logic [1:0]  wid;
    logic [31:0] tmask;
    logic [31:0] pc;
    logic        wb;
    logic [1:0]  op;
    logic        sub;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rs3;
    logic        last;
  } uop_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [31:0] perf_ops;
  logic [31:0] perf_stalls;
  logic        rand_rdy = 1'b0;
  logic        force_rdy = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int m_ops = 0;
  int m_stalls = 0;
  uop_t exp_q[$];

  tensor_hmma_sequencer_if bus();

  tensor_hmma_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .perf_ops    (perf_ops),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  task automatic chk(string name, logic [159:0] got, logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic uop_t dut_uop();
    uop_t u;
    u.uuid  = bus.out_uuid;
    u.wid   = bus.out_wid;
    u.tmask = bus.out_tmask;
    u.pc    = bus.out_pc;
    u.wb    = bus.out_wb;
    u.op    = bus.out_op_type;
    u.sub   = bus.out_substep;
    u.rd    = bus.out_rd;
    u.rs1   = bus.out_rs1;
    u.rs2   = bus.out_rs2;
    u.rs3   = bus.out_rs3;
    u.last  = bus.out_last;
    return u;
  endfunction

  task automatic push_op(logic [43:0] uuid, logic [1:0] wid,
                         logic [31:0] tmask, logic [31:0] pc, logic wb,
                         int rd, int rs1, int rs2, int rs3);
    for (int k = 0; k < 8; k++) begin
      uop_t u;
      u.uuid  = uuid;
      u.wid   = wid;
      u.tmask = tmask;
      u.pc    = pc;
      u.wb    = wb;
      u.op    = 2'(k / 2);
      u.sub   = 1'(k % 2);
      u.rd    = 6'((rd + k) % 64);
      u.rs1   = 6'((rs1 + k % 2) % 64);
      u.rs2   = 6'((rs2 + k % 2) % 64);
      u.rs3   = 6'((rs3 + k) % 64);
      u.last  = (k == 7);
      exp_q.push_back(u);
    end
  endtask

  task automatic send_op(int rd, int rs1, int rs2, int rs3);
    logic [43:0] uuid;
    logic [1:0]  wid;
    logic [31:0] tmask;
    logic [31:0] pc;
    logic        wb;
    logic        ok;
    uuid  = {12'($urandom), 32'($urandom)};
    wid   = 2'($urandom);
    tmask = $urandom;
    pc    = $urandom;
    wb    = 1'($urandom);
    bus.in_uuid     = uuid;
    bus.in_wid      = wid;
    bus.in_tmask    = tmask;
    bus.in_pc       = pc;
    bus.in_wb       = wb;
    bus.in_rd_base  = 6'(rd);
    bus.in_rs1_base = 6'(rs1);
    bus.in_rs2_base = 6'(rs2);
    bus.in_rs3_base = 6'(rs3);
    bus.in_valid    = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_op(uuid, wid, tmask, pc, wb, rd, rs1, rs2, rs3);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 160'(ok), 160'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 160'(done), 160'd1);
    chk("in_ready_after", 160'(bus.in_ready), 160'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on each uop fire and checks stall stability.
  initial begin
    uop_t cur;
    uop_t prev;
    uop_t e;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid) begin
        cur = dut_uop();
        if (prev_stall) chk("stall_stable", 160'(cur), 160'(prev));
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_uop", 160'(cur), 160'd0);
          end else begin
            e = exp_q.pop_front();
            chk("uop", 160'(cur), 160'(e));
            if (e.last) m_ops++;
          end
          prev_stall = 1'b0;
        end else begin
          m_stalls++;
          prev_stall = 1'b1;
          prev = cur;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_uuid = '0;
    bus.in_wid = '0;
    bus.in_tmask = '0;
    bus.in_pc = '0;
    bus.in_wb = 1'b0;
    bus.in_rd_base = '0;
    bus.in_rs1_base = '0;
    bus.in_rs2_base = '0;
    bus.in_rs3_base = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 160'(bus.out_valid), 160'd0);
    chk("rst_out_last", 160'(bus.out_last), 160'd0);
    chk("rst_busy", 160'(busy), 160'd0);
    chk("rst_in_ready", 160'(bus.in_ready), 160'd1);
    chk("rst_rd", 160'(bus.out_rd), 160'd0);
    chk("rst_uuid", 160'(bus.out_uuid), 160'd0);
    chk("rst_perf_ops", 160'(perf_ops), 160'd0);
    chk("rst_perf_stalls", 160'(perf_stalls), 160'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    send_op(8, 2, 4, 16);
    chk("latency", 160'(bus.out_valid), 160'd1);
    chk("busy", 160'(busy), 160'd1);
    wait_drain();

    send_op(1, 3, 5, 7);
    fork
      send_op(20, 30, 40, 50);
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          chk("no_bubble", 160'(bus.out_valid), 160'd1);
        end
      end
    join
    wait_drain();

    send_op(10, 11, 12, 13);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    force_rdy = 1'b0;
    st0 = m_stalls;
    repeat (3) @(posedge clk);
    #1;
    force_rdy = 1'b1;
    wait_drain();
`ifdef TENSOR_SEQ_PERF_EN
    chk("perf_stalls_3", 160'(perf_stalls), 160'(st0 + 3));
`else
    chk("perf_stalls_off", 160'(perf_stalls), 160'd0);
`endif

    send_op(62, 63, 63, 60);
    wait_drain();

    send_op(0, 1, 2, 3);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_ops = 0;
    m_stalls = 0;
    chk("rst_mid_valid", 160'(bus.out_valid), 160'd0);
    chk("rst_mid_busy", 160'(busy), 160'd0);
    chk("rst_mid_perf", 160'(perf_ops), 160'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_op(5, 6, 7, 9);
    chk("fresh_latency", 160'(bus.out_valid), 160'd1);
    wait_drain();

    rand_rdy = 1'b1;
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_op($urandom_range(0, 63), $urandom_range(0, 63),
              $urandom_range(0, 63), $urandom_range(0, 63));
    end
    wait_drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;

`ifdef TENSOR_SEQ_PERF_EN
    chk("perf_ops", 160'(perf_ops), 160'(m_ops));
    chk("perf_stalls", 160'(perf_stalls), 160'(m_stalls));
`else
    chk("perf_ops_off", 160'(perf_ops), 160'd0);
    chk("perf_stalls_off2", 160'(perf_stalls), 160'd0);
`endif
    chk("queue_empty", 160'(exp_q.size()), 160'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
